// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM state encoding and instruction width.
package fetch_pkg;

    localparam int STATE_W = 2;
    localparam int INSTR_W = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boot-loads IMEM from a valid/ready stream, releases IF from PC 0, then gates IF writes.
// Optional FETCH_SEQ_PERF_EN adds saturating fetch/stall performance counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    input  logic               hazard_stall,
    input  logic               redirect,
    input  logic               halt_req,
    output logic               if_write,
    output logic               if_reset,
    output logic [STATE_W-1:0] state_o,
`ifdef FETCH_SEQ_PERF_EN
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
`endif
    output logic               load_err
);

    // One extra bit so the counter can sit at IMEM_DEPTH without wrapping.
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(IMEM_DEPTH);

    fetch_state_e    state, state_nxt;
    logic [ADDR_W:0] word_cnt;
    logic            accept;
    logic            full;

    assign accept  = load_valid & load_ready;
    assign full    = (word_cnt == DEPTH_CNT);
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = load_last ? RELEASE : LOAD;
            LOAD:    if (accept && (full || load_last)) state_nxt = RELEASE;
            RELEASE: state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are combinational so IF sees stall/redirect with zero latency; reset forces safe values.
    always_comb begin
        load_ready = 1'b0;
        if_write   = 1'b0;
        if_reset   = 1'b1;
        if (!reset) begin
            case (state)
                IDLE, LOAD: load_ready = 1'b1;
                RELEASE:    if_write   = 1'b1;
                RUN: begin
                    if_reset = 1'b0;
                    if_write = redirect | (~hazard_stall & ~halt_req);
                end
                default: ;
            endcase
        end
    end

    // Loader datapath: one registered write per accepted word; overrun words are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                if (full) begin
                    load_err <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_waddr <= word_cnt[ADDR_W-1:0];
                    imem_wdata <= load_data;
                    word_cnt   <= word_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic fetch_inc, stall_inc;

    assign fetch_inc = (state == RUN) & if_write & ~redirect;
    assign stall_inc = (state == RUN) & ~if_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (fetch_inc && perf_fetch != '1) perf_fetch <= perf_fetch + 32'd1;
            if (stall_inc && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
